bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Four-master round-robin bus arbiter; sits directly upstream of the bus master multiplexer and address decoder.
- Drives the active-low grant lines that select which master's address, strobe and write data reach the shared bus. The address decoder then chip-selects the target slave from that address.
- Ownership is held until the owner releases its request, or until an optional hold-limit forces a handover.

Parameters:
- MAX_HOLD, 0: maximum consecutive cycles one master may hold the bus while another master requests. 0 disables the limit. Legal range 0..65535.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_  input  1  synchronous reset, active-low
- m0_req_  input  1  bus request, master 0, active-low
- m1_req_  input  1  bus request, master 1, active-low
- m2_req_  input  1  bus request, master 2, active-low
- m3_req_  input  1  bus request, master 3, active-low
- m0_grnt_  output  1  bus grant, master 0, active-low
- m1_grnt_  output  1  bus grant, master 1, active-low
- m2_grnt_  output  1  bus grant, master 2, active-low
- m3_grnt_  output  1  bus grant, master 3, active-low
- owner  output  2  index of the current bus owner
- arb_switch  output  1  one-cycle pulse, active-high, in the cycle after owner changes

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - reset_ is synchronous, active-low: sampled only on the rising edge of clk.
- State:
  - owner register, 2 bits.
  - hold counter, 16 bits.
  - arb_switch register.
- Reset (reset_ low at an edge):
  - owner=0, hold=0, arb_switch=0.
  - Therefore m0_grnt_=0 and m1..m3_grnt_=1.
  - This holds regardless of the request inputs.
  - Reset asserted mid-ownership returns the bus to master 0 on that edge.
- Grant decode:
  - Combinational from owner only.
  - Exactly one grant line is low at all times, including when no master requests. The idle owner keeps the bus parked.
- Owner states OWN0..OWN3. Transitions are evaluated every edge with reset_ high.
- Stay in OWNk:
  - if mk_req_=0 and the hold limit has not expired, or
  - if no other master requests.
- Release:
  - Applies when mk_req_=1, or when the hold limit has expired and another master requests.
  - Search order is k+1, k+2, k+3, k+0 (mod 4); the first requesting master becomes owner on the next edge.
  - If only mk itself requests, owner stays k.
  - If nobody requests, owner stays k.
- Hold-limit expiry:
  - The limit is expired when MAX_HOLD≠0 and hold ≥ MAX_HOLD−1 while the owner is requesting.
  - On expiry the owner is preempted only if some other master requests.
  - The preempted master is searched last (k+0), so it cannot win immediately unless it is the sole requester.
- Hold counter:
  - Cleared to 0 on any owner change.
  - Cleared when the owner's request is high.
  - Otherwise increments by 1, saturating at 0xFFFF.
  - Unused when MAX_HOLD=0.
- arb_switch:
  - Registered; equals 1 in exactly the cycle following an edge at which owner changed, otherwise 0.
- Latency:
  - A request from a non-owner, with the owner released, is granted on the first edge at which the owner's request is seen high: minimum 1 cycle.
- Simultaneous requests are resolved purely by the round-robin order above; there is no fixed priority.
- Grants never change except on a clock edge. No glitching due to input changes within a cycle.
- Asserting and releasing a request in the same cycle is not possible by construction: a request is a level.

Test Plan:
- Reset and idle: hold reset_=0 for 2 cycles with all mX_req_=1, then release and run 5 cycles.
  -> m0_grnt_=0, others 1, owner=0, arb_switch=0 throughout.
- Simple handover: from owner=0 idle, drive m2_req_=0.
  -> next edge owner=2, m2_grnt_=0, arb_switch=1 for one cycle.
  - Then m2_req_=1 with no other requests -> owner stays 2.
- Round-robin fairness: owner=1 holding, with m0, m2 and m3 requesting; drop m1_req_.
  -> owner=2; drop m2 -> owner=3; drop m3 -> owner=0.
- Hold limit: MAX_HOLD=4; m1 owns and keeps requesting; m3 requests from the cycle m1 is granted.
  -> owner switches to 3 exactly 4 cycles after the m1 grant.
  - With MAX_HOLD=0, the same stimulus -> m1 keeps the bus indefinitely (check 100 cycles).
- Sole requester at expiry: MAX_HOLD=2 and only m0 requests.
  -> owner stays 0, no arb_switch pulse, and the hold counter saturates without a wrap-induced change.
- Reset mid-operation: owner=3 with m3 requesting; assert reset_=0 for one edge.
  -> owner=0, m0_grnt_=0, hold=0 on that edge.
  - After release with m3_req_ still 0 and m0 idle -> owner=3 one edge later.

Source files
------------

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low request/grant lines.
// The current owner keeps the bus parked when idle; an optional hold limit forces handover.
module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       arb_switch
);

    typedef enum logic [1:0] {
        OWN0 = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2,
        OWN3 = 2'd3
    } state_t;

    localparam bit          HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [15:0] HOLD_LAST = HOLD_EN ? 16'(MAX_HOLD - 1) : 16'd0;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_hold;
    logic [15:0] w_nextHold;
    logic        r_switch;
    logic [3:0]  w_req;
    logic [1:0]  w_idx;
    logic        w_ownReq;
    logic        w_othersReq;
    logic        w_expired;
    logic        w_release;
    logic        w_found;

    assign w_req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

    // The owner's own slot is searched last, so a preempted master only wins back as sole requester.
    always_comb begin
        w_ownReq    = w_req[r_state];
        w_othersReq = |(w_req & ~(4'b0001 << r_state));
        w_expired   = HOLD_EN && (r_hold >= HOLD_LAST) && w_ownReq;
        w_release   = !w_ownReq || (w_expired && w_othersReq);
        w_nextState = r_state;
        w_found     = 1'b0;
        w_idx       = 2'd0;
        if (w_release) begin
            for (int i = 1; i <= 4; i++) begin
                w_idx = r_state + 2'(i);
                if (!w_found && w_req[w_idx]) begin
                    w_nextState = state_t'(w_idx);
                    w_found     = 1'b1;
                end
            end
        end
        if ((w_nextState != r_state) || !w_ownReq)
            w_nextHold = 16'd0;
        else if (r_hold != 16'hFFFF)
            w_nextHold = r_hold + 16'd1;
        else
            w_nextHold = r_hold;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_state  <= OWN0;
            r_hold   <= 16'd0;
            r_switch <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_hold   <= w_nextHold;
            r_switch <= (w_nextState != r_state);
        end
    end

    assign owner      = r_state;
    assign arb_switch = r_switch;
    assign m0_grnt_   = (r_state != OWN0);
    assign m1_grnt_   = (r_state != OWN1);
    assign m2_grnt_   = (r_state != OWN2);
    assign m3_grnt_   = (r_state != OWN3);

endmodule
